// File: rtl/hs_cdc_pkg.sv
// Shared definitions for the source-side req/ack CDC handshake.
package hs_cdc_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ_HIGH = 2'd1,
    REQ_LOW  = 2'd2
  } hs_state_e;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_TIMEOUT     = 1024;

  // A disabled timeout (0) still needs a 1-bit counter to keep widths legal.
  function automatic int cnt_width(input int timeout_cycles);
    return (timeout_cycles > 0) ? $clog2(timeout_cycles + 1) : 1;
  endfunction

endpackage

// File: rtl/hs_cdc_tx_sync.sv
// Multi-flop level synchronizer for a single asynchronous control bit.
module hs_cdc_tx_sync
  import hs_cdc_pkg::*;
#(
  parameter int num_stages = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [num_stages-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[num_stages-2:0], d_i};
    end
  end

  assign q_o = sync_q[num_stages-1];

endmodule

// File: rtl/hs_cdc_tx.sv
// Initiator side of a 4-phase req/ack handshake carrying one word across clock domains.
module hs_cdc_tx
  import hs_cdc_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              send_valid,
  input  logic [DATA_W-1:0] send_data,
  output logic              send_ready,
  output logic              req_out,
  output logic [DATA_W-1:0] data_out,
  input  logic              ack_in,
  output logic              done,
  output logic              timeout
);

  localparam int CNT_W = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  hs_state_e         state_q, state_d;
  logic              req_q, req_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              abort_q, abort_d;
  logic              done_q, done_d;
  logic              tmo_q, tmo_d;
  logic              ack_s;

  hs_cdc_tx_sync #(
    .num_stages (SYNC_STAGES)
  ) u_ack_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (ack_in),
    .q_o   (ack_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
      abort_q <= 1'b0;
      done_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
      done_q  <= done_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    abort_d = abort_q;
    done_d  = 1'b0;
    tmo_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (send_valid) begin
          data_d  = send_data;
          req_d   = 1'b1;
          cnt_d   = '0;
          abort_d = 1'b0;
          state_d = REQ_HIGH;
        end
      end

      // An ack seen on the last allowed cycle still completes normally.
      REQ_HIGH: begin
        if (ack_s) begin
          req_d   = 1'b0;
          state_d = REQ_LOW;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          req_d   = 1'b0;
          tmo_d   = 1'b1;
          abort_d = 1'b1;
          state_d = REQ_LOW;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // A late ack after an abort parks us here until the far side drops it.
      REQ_LOW: begin
        if (!ack_s) begin
          done_d  = !abort_q;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign send_ready = (state_q == IDLE);
  assign req_out    = req_q;
  assign data_out   = data_q;
  assign done       = done_q;
  assign timeout    = tmo_q;

endmodule

// File: tb/tb_hs_cdc_tx.sv
// Directed bench for hs_cdc_tx: loopback, back-to-back, timeout, late ack, collision, reset.
module tb_hs_cdc_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       send_valid;
  logic [7:0] send_data;
  logic       send_ready;
  logic       req_out;
  logic [7:0] data_out;
  logic       ack_in;
  logic       done;
  logic       timeout;

  logic       loop_en;
  logic       ack_drv;

  int n_chk = 0;
  int n_err = 0;
  int done_cnt = 0;
  int tmo_cnt = 0;
  int acc_cnt = 0;

  assign ack_in = loop_en ? req_out : ack_drv;

  always #5 clk = ~clk;

  hs_cdc_tx #(
    .DATA_W      (8),
    .SYNC_STAGES (2),
    .TIMEOUT     (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .send_valid (send_valid),
    .send_data  (send_data),
    .send_ready (send_ready),
    .req_out    (req_out),
    .data_out   (data_out),
    .ack_in     (ack_in),
    .done       (done),
    .timeout    (timeout)
  );

  always @(posedge clk) begin
    if (done)                    done_cnt <= done_cnt + 1;
    if (timeout)                 tmo_cnt  <= tmo_cnt + 1;
    if (send_valid && send_ready) acc_cnt <= acc_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one word; the following edge accepts it (edge A).
  task automatic send(input logic [7:0] d);
    send_valid = 1'b1;
    send_data  = d;
    tick();
    send_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d0, t0, a0, k, bad;

    rst_n      = 1'b0;
    send_valid = 1'b0;
    send_data  = 8'h00;
    ack_drv    = 1'b0;
    loop_en    = 1'b0;

    #2;
    check("rst_req",   req_out,    1'b0);
    check("rst_data",  data_out,   8'h00);
    check("rst_done",  done,       1'b0);
    check("rst_tmo",   timeout,    1'b0);
    check("rst_ready", send_ready, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_rst_ready", send_ready, 1'b1);

    // Loopback: req high for 3 cycles after accept, done 6 edges after accept.
    loop_en = 1'b1;
    send(8'hA5);
    check("lb_req_a0",   req_out,    1'b1);
    check("lb_data_a0",  data_out,   8'hA5);
    check("lb_ready_a0", send_ready, 1'b0);
    for (int i = 1; i <= 2; i++) begin
      tick();
      check("lb_req_hi", req_out, 1'b1);
    end
    tick();
    check("lb_req_lo",  req_out,  1'b0);
    check("lb_data_lo", data_out, 8'hA5);
    for (int i = 4; i <= 5; i++) begin
      tick();
      check("lb_done_early",  done,       1'b0);
      check("lb_ready_early", send_ready, 1'b0);
    end
    tick();
    check("lb_done",       done,       1'b1);
    check("lb_ready",      send_ready, 1'b1);
    check("lb_data_final", data_out,   8'hA5);
    tick();
    check("lb_done_1cyc", done, 1'b0);

    // Back-to-back with send_valid held high.
    d0 = done_cnt; a0 = acc_cnt;
    send_valid = 1'b1;
    send_data  = 8'h11;
    tick();
    send_data = 8'h22;
    check("b2b_data1",   data_out,   8'h11);
    check("b2b_ready1",  send_ready, 1'b0);
    k = 0; bad = 0;
    while (!send_ready && k < 20) begin
      tick();
      k++;
      if (data_out !== 8'h11) bad++;
    end
    check("b2b_wait1", k, 6);
    check("b2b_hold1", bad, 0);
    check("b2b_done1", done, 1'b1);
    tick();
    check("b2b_data2",  data_out,   8'h22);
    check("b2b_ready2", send_ready, 1'b0);
    send_valid = 1'b0;
    k = 0;
    while (!send_ready && k < 20) begin
      tick();
      k++;
    end
    check("b2b_wait2", k, 6);
    check("b2b_done2", done, 1'b1);
    check("b2b_data_end", data_out, 8'h22);
    tick();
    check("b2b_accepts", acc_cnt - a0, 2);
    check("b2b_dones",   done_cnt - d0, 2);

    // Spurious ack while idle is ignored.
    loop_en = 1'b0;
    d0 = done_cnt;
    ack_drv = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("sp_ready", send_ready, 1'b1);
      check("sp_req",   req_out,    1'b0);
    end
    ack_drv = 1'b0;
    repeat (3) tick();
    check("sp_dones", done_cnt - d0, 0);

    // Timeout with no ack: req high 8 cycles, timeout on edge A+8.
    d0 = done_cnt; t0 = tmo_cnt;
    send(8'h5A);
    for (int i = 1; i <= 7; i++) begin
      tick();
      check("to_req_hi", req_out, 1'b1);
      check("to_tmo_lo", timeout, 1'b0);
    end
    tick();
    check("to_req_lo", req_out,    1'b0);
    check("to_pulse",  timeout,    1'b1);
    check("to_ready0", send_ready, 1'b0);
    tick();
    check("to_tmo_1cyc", timeout,    1'b0);
    check("to_idle",     send_ready, 1'b1);
    check("to_no_done",  done,       1'b0);
    tick();
    check("to_tmo_cnt",  tmo_cnt - t0, 1);
    check("to_done_cnt", done_cnt - d0, 0);

    // Late ack: ack_s rises after the abort and holds REQ_LOW until it falls.
    d0 = done_cnt; t0 = tmo_cnt;
    send(8'hC3);
    repeat (6) tick();
    ack_drv = 1'b1;
    tick();
    tick();
    check("la_pulse", timeout, 1'b1);
    check("la_req",   req_out, 1'b0);
    for (int i = 9; i <= 12; i++) begin
      tick();
      check("la_hold", send_ready, 1'b0);
    end
    ack_drv = 1'b0;
    for (int i = 13; i <= 14; i++) begin
      tick();
      check("la_hold2", send_ready, 1'b0);
    end
    tick();
    check("la_idle",    send_ready, 1'b1);
    check("la_no_done", done,       1'b0);
    check("la_data",    data_out,   8'hC3);
    tick();
    check("la_tmo_cnt",  tmo_cnt - t0, 1);
    check("la_done_cnt", done_cnt - d0, 0);

    // Collision: ack_s arrives exactly when the counter hits its last value.
    t0 = tmo_cnt;
    send(8'h96);
    repeat (5) tick();
    ack_drv = 1'b1;
    tick();
    tick();
    check("co_req_hi", req_out, 1'b1);
    tick();
    check("co_req_lo", req_out, 1'b0);
    check("co_no_tmo", timeout, 1'b0);
    ack_drv = 1'b0;
    for (int i = 9; i <= 10; i++) begin
      tick();
      check("co_done_early", done, 1'b0);
    end
    tick();
    check("co_done",  done,       1'b1);
    check("co_ready", send_ready, 1'b1);
    tick();
    check("co_tmo_cnt", tmo_cnt - t0, 0);

    // Asynchronous reset in the middle of REQ_HIGH.
    loop_en = 1'b1;
    send(8'h3C);
    tick();
    check("mr_req_before", req_out, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mr_req",   req_out,    1'b0);
    check("mr_done",  done,       1'b0);
    check("mr_tmo",   timeout,    1'b0);
    check("mr_data",  data_out,   8'h00);
    check("mr_ready", send_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("mr_ready_after", send_ready, 1'b1);
    check("mr_req_after",   req_out,    1'b0);
    check("mr_done_after",  done,       1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
